vid_pix_out: RTL
================

# vid_pix_out

Downstream pixel output stage for the video timing generator. It consumes the generator's `hsync`/`vsync`/`daten` strobes and buffers a pixel stream from the frame-buffer reader in a small synchronous FIFO. It drives the registered video port with sync, data-enable and pixel data aligned on the same cycle. It also realigns the stream to frame boundaries using a start-of-frame marker, and flags underrun and misalignment.

## Interface
- `DW`, 24: pixel width (RGB888).
- `DEPTH`, 16: FIFO depth in entries; power of two, at least 4.
- `BLANK`, 0: pixel value driven when not in active video or on error.
- `clk` in 1: master clock; the only clock in the block.
- `rst` in 1: reset; synchronous, active-high.
- `ena` in 1: pixel-rate enable, the same enable used by the timing generator.
- `hsync`, `vsync`, `daten` in 1 each: timing generator outputs.
- `s_data` in DW: upstream pixel.
- `s_sof` in 1: marks the first pixel of a frame.
- `s_valid` in 1, `s_ready` out 1: upstream handshake.
- `vid_hsync`, `vid_vsync`, `vid_de` out 1 each: registered sync and data-enable outputs.
- `vid_data` out DW: registered pixel.
- `underrun` out 1: sticky; active video occurred with the FIFO empty.
- `misalign` out 1: sticky; an `s_sof` arrived at the wrong position.
- `clr_err` in 1: clears both sticky flags.
- `fifo_level` out $clog2(DEPTH)+1: current entry count.
- `line_cnt` out 16: active lines completed in the current frame.

## Operation
- FIFO entry = {s_sof, s_data}.
- Write occurs on `s_valid & s_ready`, every `clk`, independent of `ena`.
- `s_ready = !full`.
- A simultaneous push and pop leaves the level unchanged.
- Push when full is impossible, since `s_ready` is low.
- Pop when empty never occurs.
- `vsync_fall`: `vsync` was 1 on the previous `ena` cycle and is 0 on the current one. It is sampled only on `ena` cycles.
- State machine, one-hot: SEEK, ARMED, RUN. Reset enters SEEK.
  - SEEK: each `clk`, if the FIFO is non-empty and the head has `sof=0`, pop and discard. When the head has `sof=1`, go to ARMED.
  - ARMED: hold the head entry. On `vsync_fall`, go to RUN and set `first`.
  - RUN, `ena & daten`, FIFO non-empty, head `sof=0`, `first=0`: pop and output the head pixel.
  - RUN, `ena & daten`, head `sof=1`, `first=1`: pop, output the pixel, clear `first`.
  - RUN, `first=1`, head `sof=0`: set `misalign`, go to SEEK, output BLANK.
  - RUN, head `sof=1`, `first=0` (frame too short upstream): do not pop. Set `misalign`, go to ARMED, output BLANK for the rest of the frame.
  - RUN, `ena & daten`, FIFO empty: set `underrun`, output BLANK, stay in RUN. The missing pixel is not replayed.
  - RUN, `vsync_fall`: set `first` again. If the head is not `sof`, apply the `first=1`/`sof=0` rule at the first `daten`.
- Outside `daten`, or in SEEK or ARMED: `vid_data = BLANK`, no pop.
- `line_cnt`: increments on a `daten` 1→0 transition on an `ena` cycle. It clears on `vsync_fall` and wraps at 0xFFFF.
- `clr_err` on the same cycle as a new error event: the error wins and the flag stays 1.

## Timing
- Reset values: `vid_hsync`, `vid_vsync`, `vid_de` = 0; `vid_data` = BLANK; `underrun`, `misalign` = 0; `fifo_level` = 0; `line_cnt` = 0; `s_ready` = 1; state = SEEK.
- Reset asserted mid-frame flushes the FIFO and all state on that `clk` edge.
- Output registers update only on `ena` cycles, with a latency of exactly one `ena` cycle. `vid_hsync`/`vid_vsync`/`vid_de` equal `hsync`/`vsync`/`daten` delayed by one `ena` cycle. `vid_data` is aligned with `vid_de`.
- Pop and FIFO read happen on the same `ena` cycle that samples `daten`. FIFO read data is available combinationally at the head (first-word fall-through).
- `fifo_level` updates on the `clk` after the push or pop.
- SEEK discards at most one entry per `clk`.
- Sticky flags assert on the `clk` after the event.

## Structure
- Package `vid_pkg`:
  - state encodings (one-hot localparams);
  - default `DW`;
  - entry-width helper `DW+1`.
- Sub-module `vid_sync_fifo`:
  - single-clock, synchronous active-high reset;
  - parameters `W`, `DEPTH`;
  - first-word fall-through;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`;
  - pointers one bit wider than the address, for full/empty detection on wrap-around.
- Top level: FSM, edge detectors, output registers, flags, line counter.

## Test plan
- Reset, then `ena=1`; run a 4-pixel-wide, 3-line frame fed continuously with `s_sof` on pixel 0 (values 1..12). Expect `vid_data` = 1..12 under `vid_de`, one `ena` cycle after `daten`, `line_cnt` = 3, no flags.
- Push 3 pixels with `sof=0`, then one with `sof=1`. Expect SEEK to discard 3 entries in 3 `clk`s, ARMED, `fifo_level` = 1, and output starting at the `sof` pixel after `vsync_fall`.
- Stall upstream after 5 pixels of a 8-pixel line. Expect `underrun`=1 from the pixel 6 cycle, BLANK for pixels 6–8, and `vid_de` still high. Then `clr_err` → 0.
- Inject `sof` at pixel 10 of a 12-pixel frame. Expect `misalign`=1, no pop, BLANK until the next `vsync_fall`, then a correct next frame.
- Fill the FIFO to 16 entries. Expect `s_ready`=0, then 1 after one pop; simultaneous push/pop at level 8 keeps 8; pointer wrap over 40 entries preserves order.
- Assert `rst` mid-line with level 7. Expect next `clk`: level 0, outputs at reset values, SEEK.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared definitions for the video pixel output stage.
package vid_pkg;

    // Default pixel width (RGB888).
    localparam int unsigned VID_DW = 24;

    // One-hot FSM state encodings.
    localparam logic [2:0] ST_SEEK  = 3'b001;
    localparam logic [2:0] ST_ARMED = 3'b010;
    localparam logic [2:0] ST_RUN   = 3'b100;

    // A FIFO entry carries the start-of-frame marker above the pixel.
    function automatic int unsigned entry_w(input int unsigned dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/vid_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extended pointers.
module vid_sync_fifo #(
    parameter int unsigned W     = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer MSB distinguishes full from empty after wrap-around.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset flushes the contents by equalising pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; no reset needed since empty entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vid_pix_out.sv
// Pixel output stage: buffers the upstream stream, aligns it to frame
// boundaries and drives the registered video port.
module vid_pix_out
    import vid_pkg::*;
#(
    parameter int unsigned   DW    = VID_DW,
    parameter int unsigned   DEPTH = 16,
    parameter logic [DW-1:0] BLANK = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    daten,
    input  logic [DW-1:0]           s_data,
    input  logic                    s_sof,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    vid_hsync,
    output logic                    vid_vsync,
    output logic                    vid_de,
    output logic [DW-1:0]           vid_data,
    output logic                    underrun,
    output logic                    misalign,
    input  logic                    clr_err,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             line_cnt
);

    localparam int unsigned EW = entry_w(DW);

    logic [EW-1:0] head;
    logic          head_sof;
    logic [DW-1:0] head_pix;
    logic          full;
    logic          empty;
    logic          pop;

    logic [2:0]    state_q, state_d;
    logic          first_q, first_d;
    logic          vsync_prev_q;
    logic          daten_prev_q;
    logic          vsync_fall;
    logic          daten_fall;
    logic [DW-1:0] pix_d;
    logic          set_under;
    logic          set_mis;

    logic          vid_hsync_q, vid_vsync_q, vid_de_q;
    logic [DW-1:0] vid_data_q;
    logic          underrun_q, misalign_q;
    logic [15:0]   line_cnt_q;

    vid_sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid & s_ready),
        .pop   (pop),
        .din   ({s_sof, s_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign s_ready  = ~full;
    assign head_sof = head[DW];
    assign head_pix = head[DW-1:0];

    // Edges are judged between consecutive ena cycles only.
    assign vsync_fall = ena & vsync_prev_q & ~vsync;
    assign daten_fall = ena & daten_prev_q & ~daten;

    // Frame alignment: discard to a marker, wait for frame start, then stream.
    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        pop       = 1'b0;
        pix_d     = BLANK;
        set_under = 1'b0;
        set_mis   = 1'b0;
        case (state_q)
            ST_SEEK: begin
                if (!empty) begin
                    if (head_sof) state_d = ST_ARMED;
                    else          pop     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (vsync_fall) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ena && daten) begin
                    if (empty) begin
                        set_under = 1'b1;
                    end else if (first_q) begin
                        if (head_sof) begin
                            pop     = 1'b1;
                            pix_d   = head_pix;
                            first_d = 1'b0;
                        end else begin
                            set_mis = 1'b1;
                            state_d = ST_SEEK;
                        end
                    end else if (head_sof) begin
                        // Upstream frame ended early: keep its successor's marker.
                        set_mis = 1'b1;
                        state_d = ST_ARMED;
                    end else begin
                        pop   = 1'b1;
                        pix_d = head_pix;
                    end
                end
                if (vsync_fall) first_d = 1'b1;
            end
            default: state_d = ST_SEEK;
        endcase
    end

    // FSM, edge-detect history, sticky flags and line counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SEEK;
            first_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            daten_prev_q <= 1'b0;
            underrun_q   <= 1'b0;
            misalign_q   <= 1'b0;
            line_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            if (ena) begin
                vsync_prev_q <= vsync;
                daten_prev_q <= daten;
            end
            if (set_under)    underrun_q <= 1'b1;
            else if (clr_err) underrun_q <= 1'b0;
            if (set_mis)      misalign_q <= 1'b1;
            else if (clr_err) misalign_q <= 1'b0;
            if (vsync_fall)      line_cnt_q <= '0;
            else if (daten_fall) line_cnt_q <= line_cnt_q + 16'd1;
        end
    end

    // Video port registers, advanced once per ena cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_hsync_q <= 1'b0;
            vid_vsync_q <= 1'b0;
            vid_de_q    <= 1'b0;
            vid_data_q  <= BLANK;
        end else if (ena) begin
            vid_hsync_q <= hsync;
            vid_vsync_q <= vsync;
            vid_de_q    <= daten;
            vid_data_q  <= pix_d;
        end
    end

    assign vid_hsync = vid_hsync_q;
    assign vid_vsync = vid_vsync_q;
    assign vid_de    = vid_de_q;
    assign vid_data  = vid_data_q;
    assign underrun  = underrun_q;
    assign misalign  = misalign_q;
    assign line_cnt  = line_cnt_q;

endmodule
